gmem_axi_slave_mem: RTL and testbench

- AXI4 memory responder for the accelerator's 128-bit gmem master port; it is the slave end of the AW/W/B/AR/R channels.
- Backed by an on-chip word array (MEM_WORDS x 128 bits).
- Services single-outstanding INCR bursts (activation/weight reads, output writes) for simulation, FPGA bring-up and an on-chip scratch region.
- Does not reorder or interleave; one transaction at a time.

---
 rtl/gmem_axi_pkg.sv | 15 +
 rtl/gmem_byte_ram.sv | 22 ++
 rtl/gmem_axi_slave_mem.sv | 162 ++++++++++++++++
 tb/tb_gmem_axi_slave_mem.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmem_axi_pkg.sv
// Shared AXI constants and responder state encoding for the gmem slave memory.
package gmem_axi_pkg;

   localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
   localparam logic [2:0]  AXI_SIZE_16B    = 3'b100;
   localparam int unsigned BEAT_BYTES      = 16;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WR_DATA = 2'd1;
   localparam logic [1:0] ST_WR_RESP = 2'd2;
   localparam logic [1:0] ST_RD_DATA = 2'd3;

endpackage

// File: rtl/gmem_byte_ram.sv
// MEM_WORDS x 128-bit array with per-byte write enables and a combinational read port.
module gmem_byte_ram #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic                         clk,
   input  logic [$clog2(MEM_WORDS)-1:0] addr,
   input  logic [15:0]                  we,
   input  logic [127:0]                 wdata,
   output logic [127:0]                 rdata
);

   logic [127:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 16; i++) begin
         if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/gmem_axi_slave_mem.sv
// AXI4 slave memory for the 128-bit gmem port: one INCR burst at a time,
// alternating AW/AR priority on simultaneous requests.
module gmem_axi_slave_mem
   import gmem_axi_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 64,
   parameter int unsigned       DATA_W    = 128,
   parameter int unsigned       MEM_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                ap_clk,
   input  logic                ap_rst,
   input  logic                s_axi_gmem_awvalid,
   output logic                s_axi_gmem_awready,
   input  logic [ADDR_W-1:0]   s_axi_gmem_awaddr,
   input  logic [7:0]          s_axi_gmem_awlen,
   input  logic [2:0]          s_axi_gmem_awsize,
   input  logic [1:0]          s_axi_gmem_awburst,
   input  logic                s_axi_gmem_wvalid,
   output logic                s_axi_gmem_wready,
   input  logic [DATA_W-1:0]   s_axi_gmem_wdata,
   input  logic [DATA_W/8-1:0] s_axi_gmem_wstrb,
   input  logic                s_axi_gmem_wlast,
   output logic                s_axi_gmem_bvalid,
   input  logic                s_axi_gmem_bready,
   output logic [1:0]          s_axi_gmem_bresp,
   input  logic                s_axi_gmem_arvalid,
   output logic                s_axi_gmem_arready,
   input  logic [ADDR_W-1:0]   s_axi_gmem_araddr,
   input  logic [7:0]          s_axi_gmem_arlen,
   input  logic [2:0]          s_axi_gmem_arsize,
   input  logic [1:0]          s_axi_gmem_arburst,
   output logic                s_axi_gmem_rvalid,
   input  logic                s_axi_gmem_rready,
   output logic [DATA_W-1:0]   s_axi_gmem_rdata,
   output logic                s_axi_gmem_rlast,
   output logic [1:0]          s_axi_gmem_rresp
);

   localparam int unsigned     IDX_W    = $clog2(MEM_WORDS);
   localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_W+1)'(MEM_WORDS * BEAT_BYTES);

   logic [1:0]          state;
   logic                aw_rdy, ar_rdy, last_wr, err;
   logic [7:0]          len, cnt;
   logic [IDX_W-1:0]    idx;
   logic                rd_vld, rd_last;
   logic [DATA_W-1:0]   rd_data, ram_q;
   logic [1:0]          rd_resp;
   logic [DATA_W/8-1:0] ram_we;
   logic                wr_fire, addr_fire;

   // Request fields of whichever channel currently holds the one-cycle grant
   logic [ADDR_W-1:0] a_addr, a_off;
   logic [7:0]        a_len;
   logic [2:0]        a_size;
   logic [1:0]        a_burst;
   logic [ADDR_W:0]   a_last;
   logic              a_err;

   always_comb begin
      a_addr  = aw_rdy ? s_axi_gmem_awaddr  : s_axi_gmem_araddr;
      a_len   = aw_rdy ? s_axi_gmem_awlen   : s_axi_gmem_arlen;
      a_size  = aw_rdy ? s_axi_gmem_awsize  : s_axi_gmem_arsize;
      a_burst = aw_rdy ? s_axi_gmem_awburst : s_axi_gmem_arburst;
      a_off   = a_addr - BASE_ADDR;
      a_last  = {1'b0, a_addr[ADDR_W-1:4], 4'b0000} + {{(ADDR_W-11){1'b0}}, a_len, 4'b0000};
      a_err   = (a_size != AXI_SIZE_16B) || (a_burst != AXI_BURST_INCR) ||
                (a_addr < BASE_ADDR) || (a_last >= END_ADDR);
   end

   assign addr_fire = (aw_rdy && s_axi_gmem_awvalid) || (ar_rdy && s_axi_gmem_arvalid);
   assign wr_fire   = (state == ST_WR_DATA) && s_axi_gmem_wvalid;
   assign ram_we    = (wr_fire && !err) ? s_axi_gmem_wstrb : '0;

   assign s_axi_gmem_awready = aw_rdy;
   assign s_axi_gmem_arready = ar_rdy;
   assign s_axi_gmem_wready  = (state == ST_WR_DATA);
   assign s_axi_gmem_bvalid  = (state == ST_WR_RESP);
   assign s_axi_gmem_bresp   = (state == ST_WR_RESP && err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   assign s_axi_gmem_rvalid  = rd_vld;
   assign s_axi_gmem_rdata   = rd_data;
   assign s_axi_gmem_rlast   = rd_last;
   assign s_axi_gmem_rresp   = rd_resp;

   gmem_byte_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
      .clk   (ap_clk),
      .addr  (idx),
      .we    (ram_we),
      .wdata (s_axi_gmem_wdata),
      .rdata (ram_q)
   );

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state   <= ST_IDLE;
         aw_rdy  <= 1'b0;
         ar_rdy  <= 1'b0;
         last_wr <= 1'b1;
         err     <= 1'b0;
         len     <= '0;
         cnt     <= '0;
         idx     <= '0;
         rd_vld  <= 1'b0;
         rd_data <= '0;
         rd_last <= 1'b0;
         rd_resp <= AXI_RESP_OKAY;
      end else begin
         case (state)
            ST_IDLE: begin
               if (addr_fire) begin
                  len    <= a_len;
                  err    <= a_err;
                  cnt    <= '0;
                  idx    <= IDX_W'(a_off >> 4);
                  aw_rdy <= 1'b0;
                  ar_rdy <= 1'b0;
                  state  <= aw_rdy ? ST_WR_DATA : ST_RD_DATA;
               end else if (aw_rdy || ar_rdy) begin
                  aw_rdy <= 1'b0;
                  ar_rdy <= 1'b0;
               end else if (s_axi_gmem_awvalid && (!s_axi_gmem_arvalid || !last_wr)) begin
                  aw_rdy  <= 1'b1;
                  last_wr <= 1'b1;
               end else if (s_axi_gmem_arvalid) begin
                  ar_rdy  <= 1'b1;
                  last_wr <= 1'b0;
               end
            end
            ST_WR_DATA: begin
               if (s_axi_gmem_wvalid) begin
                  cnt <= cnt + 8'd1;
                  idx <= idx + IDX_W'(1);
                  if (s_axi_gmem_wlast != (cnt == len)) err <= 1'b1;
                  if (cnt == len) state <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (s_axi_gmem_bready) state <= ST_IDLE;
            end
            default: begin
               // rd_vld low only on entry; afterwards a beat is reloaded on each accept
               if (!rd_vld || s_axi_gmem_rready) begin
                  if (rd_vld && rd_last) begin
                     rd_vld  <= 1'b0;
                     rd_last <= 1'b0;
                     state   <= ST_IDLE;
                  end else begin
                     rd_vld  <= 1'b1;
                     rd_data <= err ? '0 : ram_q;
                     rd_last <= (cnt == len);
                     rd_resp <= err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                     cnt     <= cnt + 8'd1;
                     idx     <= idx + IDX_W'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gmem_axi_slave_mem.sv
// Scoreboard bench for gmem_axi_slave_mem: a word-array reference model predicts every
// R beat and B response; a separate monitor checks them as the DUT presents them.
module tb_gmem_axi_slave_mem;

   localparam int          MW   = 1024;
   localparam logic [63:0] BASE = 64'h0;

   logic         ap_clk, ap_rst;
   logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic         arvalid, arready, rvalid, rready, rlast;
   logic [63:0]  awaddr, araddr;
   logic [7:0]   awlen, arlen;
   logic [2:0]   awsize, arsize;
   logic [1:0]   awburst, arburst, bresp, rresp;
   logic [127:0] wdata, rdata;
   logic [15:0]  wstrb;

   gmem_axi_slave_mem #(.ADDR_W(64), .DATA_W(128), .MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .s_axi_gmem_awvalid(awvalid), .s_axi_gmem_awready(awready), .s_axi_gmem_awaddr(awaddr),
      .s_axi_gmem_awlen(awlen), .s_axi_gmem_awsize(awsize), .s_axi_gmem_awburst(awburst),
      .s_axi_gmem_wvalid(wvalid), .s_axi_gmem_wready(wready), .s_axi_gmem_wdata(wdata),
      .s_axi_gmem_wstrb(wstrb), .s_axi_gmem_wlast(wlast),
      .s_axi_gmem_bvalid(bvalid), .s_axi_gmem_bready(bready), .s_axi_gmem_bresp(bresp),
      .s_axi_gmem_arvalid(arvalid), .s_axi_gmem_arready(arready), .s_axi_gmem_araddr(araddr),
      .s_axi_gmem_arlen(arlen), .s_axi_gmem_arsize(arsize), .s_axi_gmem_arburst(arburst),
      .s_axi_gmem_rvalid(rvalid), .s_axi_gmem_rready(rready), .s_axi_gmem_rdata(rdata),
      .s_axi_gmem_rlast(rlast), .s_axi_gmem_rresp(rresp)
   );

   typedef struct { logic [127:0] data; logic last; logic [1:0] resp; } rbeat_t;

   rbeat_t       rq[$];
   logic [1:0]   bq[$];
   logic [127:0] mdl [MW];
   int           errors = 0;
   int           checks = 0;
   int           rmode  = 0;
   bit           last_gnt_wr = 1'b1;

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   // Back-pressure: rready follows rmode (0 always, 1 pattern 1,0,0, 2 random); bready random
   initial begin
      int ph;
      ph = 0; rready = 1'b0; bready = 1'b0;
      forever begin
         @(posedge ap_clk); #1;
         ph++;
         case (rmode)
            0:       rready = 1'b1;
            1:       rready = (ph % 3 == 0);
            default: rready = 1'($urandom_range(0, 1));
         endcase
         bready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops the scoreboard on every R/B handshake and checks stall stability
   logic         stalled = 1'b0;
   logic [127:0] pd;
   logic         pl;
   rbeat_t       e;
   logic [1:0]   eb;
   initial begin
      forever begin
         @(negedge ap_clk);
         if (ap_rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               checks++;
               if (!(rvalid && rdata === pd && rlast === pl)) begin
                  errors++;
                  $display("FAIL r_stall: rvalid=%0b rdata=%h rlast=%0b, required held rdata=%h rlast=%0b",
                           rvalid, rdata, rlast, pd, pl);
               end
            end
            stalled = rvalid && !rready;
            pd = rdata; pl = rlast;
            if (rvalid && rready) begin
               checks++;
               if (rq.size() == 0) begin
                  errors++;
                  $display("FAIL r_unexpected: got rdata=%h rlast=%0b, required no beat", rdata, rlast);
               end else begin
                  e = rq.pop_front();
                  if (rdata !== e.data || rlast !== e.last || rresp !== e.resp) begin
                     errors++;
                     $display("FAIL r_beat: got data=%h last=%0b resp=%b, required data=%h last=%0b resp=%b",
                              rdata, rlast, rresp, e.data, e.last, e.resp);
                  end
               end
            end
            if (bvalid && bready) begin
               checks++;
               if (bq.size() == 0) begin
                  errors++;
                  $display("FAIL b_unexpected: got bresp=%b, required no response", bresp);
               end else begin
                  eb = bq.pop_front();
                  if (bresp !== eb) begin
                     errors++;
                     $display("FAIL b_resp: got bresp=%b, required %b", bresp, eb);
                  end
               end
            end
         end
      end
   end

   function automatic bit req_err(input logic [63:0] addr, input int len,
                                  input logic [2:0] size, input logic [1:0] burst);
      logic [64:0] last_a, lim;
      last_a = {1'b0, addr[63:4], 4'h0} + 65'(len) * 65'd16;
      lim    = {1'b0, BASE} + 65'(MW) * 65'd16;
      return (size != 3'b100) || (burst != 2'b01) || (addr < BASE) || (last_a >= lim);
   endfunction

   function automatic int widx(input logic [63:0] addr);
      logic [63:0] off;
      off = (addr - BASE) >> 4;
      return int'(off % 64'(MW));
   endfunction

   task automatic timeout(input string nm);
      checks++; errors++;
      $display("FAIL %s: timeout, got no handshake, required one within bound", nm);
   endtask

   task automatic issue_addr(input bit is_w, input logic [63:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst);
      bit ok;
      ok = 1'b0;
      if (is_w) begin
         awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
      end else begin
         araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
      end
      for (int t = 0; t < 300 && !ok; t++) begin
         @(negedge ap_clk);
         ok = is_w ? awready : arready;
      end
      if (!ok) timeout(is_w ? "aw_ready" : "ar_ready");
      @(posedge ap_clk); #1;
      if (is_w) awvalid = 1'b0; else arvalid = 1'b0;
      last_gnt_wr = is_w;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((rq.size() != 0 || bq.size() != 0) && t < 5000) begin
         @(negedge ap_clk); t++;
      end
      if (rq.size() != 0 || bq.size() != 0) begin
         timeout("drain");
         rq.delete(); bq.delete();
      end
      @(posedge ap_clk); #1;
   endtask

   // W phase; model updated per the rule that an error seen on a beat masks later beats only
   task automatic w_phase(input logic [63:0] addr, input int len, input bit err0, input int early,
                          input int smode, input int dmode, input int stop_after);
      bit err, lst, ok;
      int base;
      logic [127:0] d;
      logic [15:0] s;
      err = err0; base = widx(addr);
      for (int k = 0; k <= len; k++) begin
         if (k == stop_after) return;
         case (dmode)
            0:       d = 128'(k);
            1:       d = {$urandom, $urandom, $urandom, $urandom};
            2:       d = '1;
            default: d = '0;
         endcase
         s = (smode == 0) ? 16'hFFFF : (smode == 1) ? 16'($urandom) : 16'h00FF;
         lst = (k == len) || (k == early);
         wdata = d; wstrb = s; wlast = lst; wvalid = 1'b1;
         ok = 1'b0;
         for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge ap_clk);
            ok = wready;
         end
         if (!ok) begin
            timeout("w_ready");
            wvalid = 1'b0;
            return;
         end
         if (!err)
            for (int b = 0; b < 16; b++)
               if (s[b]) mdl[(base + k) % MW][b*8 +: 8] = d[b*8 +: 8];
         if (lst != (k == len)) err = 1'b1;
         @(posedge ap_clk); #1;
         wvalid = 1'b0; wlast = 1'b0;
      end
      bq.push_back(err ? 2'b10 : 2'b00);
   endtask

   task automatic push_read(input logic [63:0] addr, input int len, input bit err);
      rbeat_t r;
      for (int k = 0; k <= len; k++) begin
         r.data = err ? '0 : mdl[(widx(addr) + k) % MW];
         r.last = (k == len);
         r.resp = err ? 2'b10 : 2'b00;
         rq.push_back(r);
      end
   endtask

   task automatic do_write(input logic [63:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int early, input int smode, input int dmode);
      issue_addr(1'b1, addr, len, size, burst);
      w_phase(addr, len, req_err(addr, len, size, burst), early, smode, dmode, -1);
      drain();
   endtask

   task automatic do_read(input logic [63:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int mode);
      rmode = mode;
      push_read(addr, len, req_err(addr, len, size, burst));
      issue_addr(1'b0, addr, len, size, burst);
      drain();
   endtask

   // AW and AR raised in the same cycle; the model expects the channel opposite the last grant
   task automatic do_tie(input logic [63:0] wa, input int wl, input logic [63:0] ra, input int rl);
      bit exp_rd_first, rd, wd, hr, hw;
      int first;
      exp_rd_first = last_gnt_wr;
      rd = 0; wd = 0; first = -1;
      rmode = 0;
      push_read(ra, rl, 1'b0);
      awaddr = wa; awlen = 8'(wl); awsize = 3'b100; awburst = 2'b01;
      araddr = ra; arlen = 8'(rl); arsize = 3'b100; arburst = 2'b01;
      awvalid = 1'b1; arvalid = 1'b1;
      for (int t = 0; t < 400 && !wd; t++) begin
         @(negedge ap_clk);
         hr = arvalid && arready; hw = awvalid && awready;
         if (hr && first < 0) first = 0;
         if (hw && first < 0) first = 1;
         @(posedge ap_clk); #1;
         if (hr) begin arvalid = 1'b0; rd = 1; end
         if (hw) begin awvalid = 1'b0; wd = 1; end
      end
      if (!wd) begin timeout("tie_aw"); awvalid = 1'b0; end
      else w_phase(wa, wl, 1'b0, -1, 1, 1, -1);
      for (int t = 0; t < 400 && !rd; t++) begin
         @(negedge ap_clk);
         hr = arvalid && arready;
         @(posedge ap_clk); #1;
         if (hr) begin arvalid = 1'b0; rd = 1; end
      end
      if (!rd) begin timeout("tie_ar"); arvalid = 1'b0; end
      checks++;
      if (first != (exp_rd_first ? 0 : 1)) begin
         errors++;
         $display("FAIL tie_order: got first=%s, required %s", first == 0 ? "read" : "write",
                  exp_rd_first ? "read" : "write");
      end
      last_gnt_wr = exp_rd_first;
      drain();
   endtask

   task automatic chk_reset_outs(input string nm);
      checks++;
      if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0 || rdata !== '0 ||
          bresp !== 2'b00 || rresp !== 2'b00) begin
         errors++;
         $display("FAIL %s: got aw/ar/w/b/r/last=%b rdata=%h bresp=%b rresp=%b, required all zero",
                  nm, {awready, arready, wready, bvalid, rvalid, rlast}, rdata, bresp, rresp);
      end
   endtask

   initial begin
      logic [63:0] a;
      int l;
      ap_rst = 1'b1;
      awvalid = 0; arvalid = 0; wvalid = 0; wlast = 0;
      awaddr = '0; araddr = '0; awlen = '0; arlen = '0;
      awsize = '0; arsize = '0; awburst = '0; arburst = '0;
      wdata = '0; wstrb = '0;
      for (int i = 0; i < MW; i++) mdl[i] = '0;
      repeat (3) @(posedge ap_clk);
      #1 chk_reset_outs("reset_state");
      ap_rst = 1'b0;
      @(posedge ap_clk); #1;

      for (int i = 0; i < 4; i++) do_write(BASE + 64'(i * 4096), 255, 3'b100, 2'b01, -1, 0, 3);

      do_write(BASE, 15, 3'b100, 2'b01, -1, 0, 0);
      do_read(BASE, 15, 3'b100, 2'b01, 0);

      do_write(BASE + 64'h40, 0, 3'b100, 2'b01, -1, 2, 2);
      do_read(BASE + 64'h40, 0, 3'b100, 2'b01, 0);

      do_tie(BASE + 64'h800, 3, BASE + 64'h100, 2);
      do_read(BASE + 64'h800, 3, 3'b100, 2'b01, 2);
      do_tie(BASE + 64'h900, 2, BASE + 64'h800, 3);

      do_read(BASE + 64'(MW * 16 - 16), 1, 3'b100, 2'b01, 0);
      do_write(BASE + 64'h100, 3, 3'b010, 2'b01, -1, 0, 1);
      do_read(BASE + 64'h100, 3, 3'b100, 2'b01, 0);

      do_read(BASE + 64'h900, 3, 3'b100, 2'b01, 1);
      do_write(BASE + 64'hA00, 3, 3'b100, 2'b01, 1, 0, 1);
      do_read(BASE + 64'hA00, 3, 3'b100, 2'b01, 0);

      // Reset mid-burst: five beats land, the rest of the burst and its response never happen
      issue_addr(1'b1, BASE + 64'h200, 15, 3'b100, 2'b01);
      w_phase(BASE + 64'h200, 15, 1'b0, -1, 0, 1, 5);
      #2 ap_rst = 1'b1;
      #1 chk_reset_outs("reset_mid_write");
      @(posedge ap_clk); #1 ap_rst = 1'b0;
      last_gnt_wr = 1'b1;
      @(posedge ap_clk); #1;
      do_read(BASE + 64'h200, 15, 3'b100, 2'b01, 2);

      for (int i = 0; i < 40; i++) begin
         l = $urandom_range(0, 15);
         a = BASE + 64'($urandom_range(0, MW - 1 - l)) * 64'd16 + 64'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) a = BASE + 64'($urandom_range(MW - 8, MW - 1)) * 64'd16;
         if ($urandom_range(0, 1) == 1)
            do_write(a, l, ($urandom_range(0, 9) == 0) ? 3'b011 : 3'b100,
                     ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b01,
                     ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : -1, 1, 1);
         else
            do_read(a, l, ($urandom_range(0, 9) == 0) ? 3'b101 : 3'b100,
                    ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01, $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
